// File: rtl/vx_gpu_pkg.sv
// Shared widths, commit beat layout and lock-state encoding for the commit path.
package vx_gpu_pkg;

  localparam int unsigned NUM_INPUTS_C  = 4;
  localparam int unsigned NUM_THREADS_C = 4;
  localparam int unsigned NW_BITS_C     = 2;
  localparam int unsigned NR_BITS_C     = 6;
  localparam int unsigned UUID_BITS_C   = 44;
  localparam int unsigned XLEN_C        = 32;

  typedef struct packed {
    logic [UUID_BITS_C-1:0]          uuid;
    logic [NW_BITS_C-1:0]            wid;
    logic [NUM_THREADS_C-1:0]        tmask;
    logic [XLEN_C-1:0]               PC;
    logic [NR_BITS_C-1:0]            rd;
    logic                            wb;
    logic                            eop;
    logic [NUM_THREADS_C*XLEN_C-1:0] data;
  } commit_beat_t;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

  function automatic int unsigned rr_index(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// Rotating-priority arbiter that stays locked to one requester for the
// duration of a multi-beat instruction.
module vx_rr_lock_arbiter
  import vx_gpu_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                accept,
  input  logic                accept_eop,
  output logic [NUM_REQS-1:0] grant
);

  localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  lock_state_e state_q, state_d;
  idx_t        ptr_q, ptr_d;
  idx_t        lock_idx_q, lock_idx_d;
  idx_t        grant_idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (state_q == LOCK_LOCKED) begin
      // Other sources stall even when the lock owner is idle.
      if (requests[lock_idx_q]) begin
        grant[lock_idx_q] = 1'b1;
        grant_idx         = lock_idx_q;
      end
    end else begin
      for (int unsigned off = 0; off < NUM_REQS; off++) begin
        if (!found && requests[idx_t'(rr_index(32'(ptr_q), off, NUM_REQS))]) begin
          found     = 1'b1;
          grant_idx = idx_t'(rr_index(32'(ptr_q), off, NUM_REQS));
          grant[grant_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      if (accept_eop) begin
        state_d = LOCK_UNLOCKED;
        ptr_d   = idx_t'(rr_next(32'(grant_idx), NUM_REQS));
      end else begin
        state_d    = LOCK_LOCKED;
        lock_idx_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= LOCK_UNLOCKED;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Merges per-unit commit streams into one registered writeback stream and
// counts retired instructions.
module vx_commit_arbiter
  import vx_gpu_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = NUM_INPUTS_C,
  parameter int unsigned NUM_THREADS = NUM_THREADS_C,
  parameter int unsigned NW_BITS     = NW_BITS_C,
  parameter int unsigned NR_BITS     = NR_BITS_C,
  parameter int unsigned UUID_BITS   = UUID_BITS_C
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_INPUTS-1:0]               in_valid,
  output logic [NUM_INPUTS-1:0]               in_ready,
  input  logic [NUM_INPUTS*UUID_BITS-1:0]     in_uuid,
  input  logic [NUM_INPUTS*NW_BITS-1:0]       in_wid,
  input  logic [NUM_INPUTS*NUM_THREADS-1:0]   in_tmask,
  input  logic [NUM_INPUTS*32-1:0]            in_PC,
  input  logic [NUM_INPUTS*NR_BITS-1:0]       in_rd,
  input  logic [NUM_INPUTS-1:0]               in_wb,
  input  logic [NUM_INPUTS-1:0]               in_eop,
  input  logic [NUM_INPUTS*NUM_THREADS*32-1:0] in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [UUID_BITS-1:0]                out_uuid,
  output logic [NW_BITS-1:0]                  out_wid,
  output logic [NUM_THREADS-1:0]              out_tmask,
  output logic [31:0]                         out_PC,
  output logic [NR_BITS-1:0]                  out_rd,
  output logic                                out_wb,
  output logic                                out_eop,
  output logic [NUM_THREADS*32-1:0]           out_data,
  output logic [63:0]                         perf_instrs
);

  commit_beat_t          in_beats [NUM_INPUTS];
  commit_beat_t          sel_beat;
  commit_beat_t          out_beat_q, out_beat_d;
  logic                  out_valid_q, out_valid_d;
  logic [63:0]           perf_q, perf_d;
  logic [NUM_INPUTS-1:0] grant;
  logic                  load_en;
  logic                  accept;

  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      in_beats[i]       = '0;
      in_beats[i].uuid  = in_uuid[i*UUID_BITS +: UUID_BITS];
      in_beats[i].wid   = in_wid[i*NW_BITS +: NW_BITS];
      in_beats[i].tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
      in_beats[i].PC    = in_PC[i*32 +: 32];
      in_beats[i].rd    = in_rd[i*NR_BITS +: NR_BITS];
      in_beats[i].wb    = in_wb[i];
      in_beats[i].eop   = in_eop[i];
      in_beats[i].data  = in_data[i*NUM_THREADS*32 +: NUM_THREADS*32];
    end
  end

  always_comb begin
    sel_beat = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) sel_beat = in_beats[i];
    end
  end

  assign load_en  = ~out_valid_q | out_ready;
  assign in_ready = grant & {NUM_INPUTS{load_en & reset}};
  assign accept   = |(in_ready & in_valid);

  vx_rr_lock_arbiter #(
    .NUM_REQS (NUM_INPUTS)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .requests   (in_valid),
    .accept     (accept),
    .accept_eop (sel_beat.eop),
    .grant      (grant)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    perf_d      = perf_q;
    if (load_en) begin
      out_valid_d = accept;
      if (accept) out_beat_d = sel_beat;
    end
    // Retirement is counted at the downstream handshake of the last beat.
    if (out_valid_q & out_ready & out_beat_q.eop) perf_d = perf_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
      perf_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
      perf_q      <= perf_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_uuid    = out_beat_q.uuid;
  assign out_wid     = out_beat_q.wid;
  assign out_tmask   = out_beat_q.tmask;
  assign out_PC      = out_beat_q.PC;
  assign out_rd      = out_beat_q.rd;
  assign out_wb      = out_beat_q.wb;
  assign out_eop     = out_beat_q.eop;
  assign out_data    = out_beat_q.data;
  assign perf_instrs = perf_q;

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Scoreboard bench for vx_commit_arbiter: queue-based source/arbitration model
// predicts accepted beats; a negedge monitor checks the output register.
module tb_vx_commit_arbiter;

  localparam int NI = 4;

  typedef struct packed {
    logic [43:0]  uuid;
    logic [1:0]   wid;
    logic [3:0]   tmask;
    logic [31:0]  pc;
    logic [5:0]   rd;
    logic         wb;
    logic         eop;
    logic [127:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    in_valid, in_ready;
  logic [175:0]  in_uuid;
  logic [7:0]    in_wid;
  logic [15:0]   in_tmask;
  logic [127:0]  in_PC;
  logic [23:0]   in_rd;
  logic [3:0]    in_wb, in_eop;
  logic [511:0]  in_data;
  logic          out_valid, out_ready;
  logic [43:0]   out_uuid;
  logic [1:0]    out_wid;
  logic [3:0]    out_tmask;
  logic [31:0]   out_PC;
  logic [5:0]    out_rd;
  logic          out_wb, out_eop;
  logic [127:0]  out_data;
  logic [63:0]   perf_instrs;

  always #5 clk = ~clk;

  vx_commit_arbiter #(
    .NUM_INPUTS  (4),
    .NUM_THREADS (4),
    .NW_BITS     (2),
    .NR_BITS     (6),
    .UUID_BITS   (44)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_uuid     (in_uuid),
    .in_wid      (in_wid),
    .in_tmask    (in_tmask),
    .in_PC       (in_PC),
    .in_rd       (in_rd),
    .in_wb       (in_wb),
    .in_eop      (in_eop),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_uuid    (out_uuid),
    .out_wid     (out_wid),
    .out_tmask   (out_tmask),
    .out_PC      (out_PC),
    .out_rd      (out_rd),
    .out_wb      (out_wb),
    .out_eop     (out_eop),
    .out_data    (out_data),
    .perf_instrs (perf_instrs)
  );

  beat_t             src_q [NI][$];
  beat_t             exp_q [$];
  int                m_ptr = 0;
  int                m_owner = -1;
  int                pend_win = -1;
  logic              rst_cur = 1'b0;
  bit                auto_gen = 1'b0;
  longint unsigned   mon_perf = 0;
  int                tests = 0;
  int                fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_instr(input int src, input int nb, input logic [5:0] rd, input logic wb,
                            input logic [3:0] tmask, input bit fixdata, input logic [31:0] dval);
    beat_t b;
    logic [63:0] r;
    r       = {$urandom(), $urandom()};
    b.uuid  = r[43:0];
    b.wid   = 2'($urandom_range(0, 3));
    b.tmask = tmask;
    b.pc    = $urandom();
    b.rd    = rd;
    b.wb    = wb;
    for (int k = 0; k < nb; k++) begin
      b.data = fixdata ? {4{dval}} : {$urandom(), $urandom(), $urandom(), $urandom()};
      b.eop  = (k == nb - 1);
      src_q[src].push_back(b);
    end
  endtask

  // One clock: retire the previous cycle's predicted acceptance, drive new
  // inputs, then predict this cycle's grant and check in_ready against it.
  task automatic step(input logic rst_v, input logic rdy_v);
    logic [NI-1:0] v;
    logic [NI-1:0] er;
    int            win;
    bit            load;
    beat_t         b;
    @(posedge clk);
    #1;
    if (!rst_cur) begin
      m_ptr   = 0;
      m_owner = -1;
      exp_q.delete();
      mon_perf = 0;
      for (int i = 0; i < NI; i++) src_q[i].delete();
    end else if (pend_win >= 0) begin
      b = src_q[pend_win].pop_front();
      exp_q.push_back(b);
      if (b.eop) begin
        m_owner = -1;
        m_ptr   = (pend_win + 1) % NI;
      end else begin
        m_owner = pend_win;
      end
    end
    if (auto_gen) begin
      for (int i = 0; i < NI; i++)
        if (src_q[i].size() == 0 && $urandom_range(0, 2) == 0)
          push_instr(i, $urandom_range(1, 3), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 1'b0, 32'h0);
    end
    rst_cur   = rst_v;
    reset     = rst_v;
    out_ready = rdy_v;
    for (int i = 0; i < NI; i++) begin
      beat_t f;
      f = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      v[i] = (src_q[i].size() > 0) && (!auto_gen || $urandom_range(0, 3) != 0);
      in_uuid[i*44 +: 44]   = f.uuid;
      in_wid[i*2 +: 2]      = f.wid;
      in_tmask[i*4 +: 4]    = f.tmask;
      in_PC[i*32 +: 32]     = f.pc;
      in_rd[i*6 +: 6]       = f.rd;
      in_wb[i]              = f.wb;
      in_eop[i]             = f.eop;
      in_data[i*128 +: 128] = f.data;
    end
    in_valid = v;
    #1;
    win = -1;
    er  = '0;
    if (rst_cur) begin
      load = (exp_q.size() == 0) || out_ready;
      if (m_owner >= 0) begin
        if (v[m_owner]) win = m_owner;
      end else begin
        for (int k = 0; k < NI; k++)
          if (win < 0 && v[(m_ptr + k) % NI]) win = (m_ptr + k) % NI;
      end
      if (!load) win = -1;
      if (win >= 0) er[win] = 1'b1;
    end
    pend_win = win;
    check("in_ready", 256'(in_ready), 256'(er));
  endtask

  task automatic run(input int n, input logic rdy);
    repeat (n) step(1'b1, rdy);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0)
        check("beat", 256'({out_uuid, out_wid, out_tmask, out_PC, out_rd, out_wb, out_eop, out_data}),
              256'(exp_q[0]));
      check("perf_instrs", 256'(perf_instrs), 256'(mon_perf));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        if (exp_q[0].eop) mon_perf++;
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int remaining;
    reset = 1'b0; out_ready = 1'b0; in_valid = '0;
    in_uuid = '0; in_wid = '0; in_tmask = '0; in_PC = '0; in_rd = '0;
    in_wb = '0; in_eop = '0; in_data = '0;
    repeat (3) step(1'b0, 1'b1);

    push_instr(0, 1, 6'd5, 1'b1, 4'hF, 1'b1, 32'hA5);
    run(3, 1'b1);

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NI; i++)
        push_instr(i, 1, 6'($urandom_range(0, 63)), 1'b1, 4'hF, 1'b0, 32'h0);
    run(10, 1'b1);

    push_instr(1, 1, 6'd1, 1'b1, 4'hF, 1'b0, 32'h0);
    run(3, 1'b1);
    push_instr(2, 3, 6'd2, 1'b1, 4'hF, 1'b0, 32'h0);
    push_instr(0, 1, 6'd3, 1'b1, 4'hF, 1'b0, 32'h0);
    push_instr(3, 1, 6'd4, 1'b1, 4'hF, 1'b0, 32'h0);
    run(8, 1'b1);

    for (int i = 0; i < 3; i++) begin
      push_instr(i, 1, 6'd7, 1'b1, 4'h3, 1'b0, 32'h0);
      push_instr(i, 1, 6'd8, 1'b1, 4'h5, 1'b0, 32'h0);
    end
    run(5, 1'b0);
    run(10, 1'b1);

    push_instr(1, 3, 6'd9, 1'b1, 4'hF, 1'b0, 32'h0);
    run(2, 1'b1);
    step(1'b0, 1'b1);
    push_instr(0, 1, 6'd10, 1'b1, 4'hF, 1'b0, 32'h0);
    push_instr(2, 1, 6'd11, 1'b1, 4'hF, 1'b0, 32'h0);
    run(6, 1'b1);

    push_instr(3, 1, 6'd12, 1'b0, 4'h0, 1'b0, 32'h0);
    run(3, 1'b1);

    auto_gen = 1'b1;
    repeat (3000) step(1'b1, 1'($urandom_range(0, 9) < 7));
    auto_gen = 1'b0;

    remaining = 1;
    for (int n = 0; n < 300 && remaining != 0; n++) begin
      step(1'b1, 1'b1);
      remaining = exp_q.size();
      for (int i = 0; i < NI; i++) remaining += src_q[i].size();
    end
    check("drain", 256'(remaining), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
